// File: rtl/i2c_target_pkg.sv
// Shared types and codec constants for the SSM2603 control-port responder.
package i2c_target_pkg;

    localparam logic [6:0] SSM2603_ADDR     = 7'h1A;
    localparam int         SSM2603_NUM_REGS = 19;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WR_B1,
        WR_B1_ACK,
        WR_B2,
        WR_B2_ACK,
        RD_BYTE,
        RD_MACK,
        IGNORE
    } i2c_tgt_state_t;

    // Filtered bus events, each a single board_clk pulse, plus the filtered SDA level.
    typedef struct packed {
        logic scl_rise;
        logic scl_fall;
        logic start;
        logic stop;
        logic sda;
    } bus_evt_t;

endpackage

// File: rtl/i2c_bus_sync.sv
// Pad synchroniser, stability filter and bus-condition detector for SCL/SDA.
module i2c_bus_sync
    import i2c_target_pkg::*;
#(
    parameter int FILTER_LEN = 4
) (
    input  logic     board_clk,
    input  logic     reset,
    input  logic     scl_i,
    input  logic     sda_i,
    output bus_evt_t evt
);

    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    // Line 0 is SCL, line 1 is SDA.
    logic [1:0]         s1, s2, filt, prev;
    logic [1:0][CW-1:0] cnt;

    // Two-stage synchroniser; pads are asynchronous so these carry no reset.
    always_ff @(posedge board_clk) begin
        s1 <= {sda_i, scl_i};
        s2 <= s1;
    end

    // Accept a new level only after FILTER_LEN consecutive differing samples.
    // Reset adopts the current pad levels so no phantom edge follows reset.
    always_ff @(posedge board_clk) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                filt[i] <= s2[i];
                cnt[i]  <= '0;
            end else if (s2[i] == filt[i]) begin
                cnt[i]  <= '0;
            end else if (cnt[i] == CW'(FILTER_LEN - 1)) begin
                filt[i] <= s2[i];
                cnt[i]  <= '0;
            end else begin
                cnt[i]  <= cnt[i] + 1'b1;
            end
        end
    end

    // Previous filtered levels for edge detection.
    always_ff @(posedge board_clk) begin
        if (reset) prev <= s2;
        else       prev <= filt;
    end

    // START/STOP qualify SCL with its previous level so an SDA change landing on
    // the same sample as an SCL fall is still taken as a bus condition.
    assign evt.scl_rise =  filt[0] & ~prev[0];
    assign evt.scl_fall = ~filt[0] &  prev[0];
    assign evt.start    =  prev[1] & ~filt[1] & prev[0];
    assign evt.stop     = ~prev[1] &  filt[1] & prev[0];
    assign evt.sda      =  filt[1];

endmodule

// File: rtl/i2c_codec_target.sv
// I2C responder modelling the SSM2603 control port: 2-byte register writes, register reads.
module i2c_codec_target
    import i2c_target_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR   = SSM2603_ADDR,
    parameter int         NUM_REGS   = SSM2603_NUM_REGS,
    parameter int         FILTER_LEN = 4
) (
    input  logic       board_clk,
    input  logic       reset,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_pull,
    input  logic [4:0] reg_rd_idx,
    output logic [8:0] reg_rd_data,
    output logic       wr_valid,
    output logic [6:0] wr_idx,
    output logic [8:0] wr_data,
    output logic       busy
);

    localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    bus_evt_t             evt;
    i2c_tgt_state_t       state, state_nxt;
    logic [2:0]           bit_cnt;
    logic [7:0]           shift;
    logic [6:0]           ptr;
    logic                 d8, rw, ack_hi, rd_lo, mack;
    logic [NUM_REGS-1:0][8:0] regs;

    logic [7:0] byte_in, rd_byte;
    logic [8:0] rd_word;
    logic       byte_done, ack_state, ptr_ok;
    logic       ack_drive, load_rd, commit;

    i2c_bus_sync #(.FILTER_LEN(FILTER_LEN)) u_sync (
        .board_clk (board_clk),
        .reset     (reset),
        .scl_i     (scl_i),
        .sda_i     (sda_i),
        .evt       (evt)
    );

    assign byte_in   = {shift[6:0], evt.sda};
    assign byte_done = evt.scl_rise && (bit_cnt == 3'd7);
    assign ack_state = (state == ADDR_ACK) || (state == WR_B1_ACK) ||
                       (state == WR_B2_ACK) || (state == RD_MACK);
    assign ptr_ok    = int'(ptr) < NUM_REGS;
    assign rd_word   = ptr_ok ? regs[IW'(ptr)] : 9'h000;
    // Reads alternate between the MSB-only byte and the low byte of the register.
    assign rd_byte   = rd_lo ? rd_word[7:0] : {7'b0, rd_word[8]};
    assign busy      = (state != IDLE);

    assign reg_rd_data = (int'(reg_rd_idx) < NUM_REGS) ? regs[IW'(reg_rd_idx)] : 9'h000;

    // State register.
    always_ff @(posedge board_clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state plus the per-state ACK level, read-load and commit strobes.
    always_comb begin
        state_nxt = state;
        ack_drive = 1'b0;
        load_rd   = 1'b0;
        commit    = 1'b0;
        case (state)
            ADDR_ACK:  begin ack_drive = 1'b1;   load_rd = rw;   end
            WR_B1_ACK: ack_drive = 1'b1;
            WR_B2_ACK: begin
                ack_drive = ptr_ok;
                commit    = evt.scl_rise && !ack_hi && ptr_ok;
            end
            RD_MACK:   load_rd = mack;
            default:   ;
        endcase
        if (evt.start) begin
            state_nxt = ADDR;
        end else if (evt.stop) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                ADDR:      if (byte_done) state_nxt = (byte_in[7:1] == DEV_ADDR) ? ADDR_ACK : IGNORE;
                ADDR_ACK:  if (evt.scl_fall && ack_hi) state_nxt = rw ? RD_BYTE : WR_B1;
                WR_B1:     if (byte_done) state_nxt = WR_B1_ACK;
                WR_B1_ACK: if (evt.scl_fall && ack_hi) state_nxt = WR_B2;
                WR_B2:     if (byte_done) state_nxt = WR_B2_ACK;
                WR_B2_ACK: if (evt.scl_fall && ack_hi) state_nxt = WR_B1;
                RD_BYTE:   if (byte_done) state_nxt = RD_MACK;
                RD_MACK:   if (evt.scl_fall && ack_hi) state_nxt = mack ? RD_BYTE : IGNORE;
                default:   ;
            endcase
        end
    end

    // Datapath: bit shifting on SCL rise, SDA drive on SCL fall, register commit.
    always_ff @(posedge board_clk) begin
        if (reset) begin
            bit_cnt  <= '0;
            shift    <= '0;
            ptr      <= '0;
            d8       <= 1'b0;
            rw       <= 1'b0;
            ack_hi   <= 1'b0;
            rd_lo    <= 1'b0;
            mack     <= 1'b0;
            sda_pull <= 1'b0;
            wr_valid <= 1'b0;
            wr_idx   <= '0;
            wr_data  <= '0;
            regs     <= '0;
        end else begin
            wr_valid <= 1'b0;
            if (evt.start) begin
                bit_cnt  <= '0;
                ack_hi   <= 1'b0;
                rd_lo    <= 1'b0;
                sda_pull <= 1'b0;
            end else if (evt.stop) begin
                ack_hi   <= 1'b0;
                sda_pull <= 1'b0;
            end else if (evt.scl_rise) begin
                case (state)
                    ADDR, WR_B1, WR_B2: begin
                        shift   <= byte_in;
                        bit_cnt <= bit_cnt + 3'd1;
                        if (byte_done && state == ADDR) rw <= evt.sda;
                        if (byte_done && state == WR_B1) begin
                            ptr <= byte_in[7:1];
                            d8  <= evt.sda;
                        end
                    end
                    RD_BYTE: bit_cnt <= bit_cnt + 3'd1;
                    ADDR_ACK, WR_B1_ACK, WR_B2_ACK, RD_MACK: begin
                        ack_hi <= 1'b1;
                        if (state == RD_MACK) mack <= ~evt.sda;
                        if (commit) begin
                            regs[IW'(ptr)] <= {d8, shift};
                            wr_valid       <= 1'b1;
                            wr_idx         <= ptr;
                            wr_data        <= {d8, shift};
                        end
                    end
                    default: ;
                endcase
            end else if (evt.scl_fall) begin
                if (ack_state && !ack_hi) begin
                    sda_pull <= ack_drive;
                end else if (ack_state) begin
                    ack_hi  <= 1'b0;
                    bit_cnt <= '0;
                    if (load_rd) begin
                        sda_pull <= ~rd_byte[7];
                        shift    <= {rd_byte[6:0], 1'b0};
                        rd_lo    <= ~rd_lo;
                    end else begin
                        sda_pull <= 1'b0;
                    end
                end else if (state == RD_BYTE) begin
                    sda_pull <= ~shift[7];
                    shift    <= {shift[6:0], 1'b0};
                end
            end
        end
    end

endmodule
